// File: rtl/sm_mac_if.sv
// -----------------------------------------------------------------------------
// sm_mac_if
// Handshake and data bundle for the sign-magnitude MAC accumulator.
//
// Parameters
//   DATA_W : operand width, sign-magnitude (MSB = sign)
//   ACC_W  : result width, sign-magnitude (MSB = sign)
//
// Signals
//   start     : begin a dot product (honoured only while the block is idle)
//   in_valid  : x/w beat valid
//   in_ready  : block accepts a beat
//   x, w      : activation and weight, sign-magnitude
//   out_valid : result valid
//   out_ready : consumer takes the result
//   result    : accumulated sum, sign-magnitude
//   ovf       : sticky saturation flag for the current result
//   busy      : block is not idle
//
// Modports
//   master : producer/consumer side (drives start, beats and out_ready)
//   slave  : the accumulator itself
// -----------------------------------------------------------------------------
interface sm_mac_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24
);
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] x;
  logic [DATA_W-1:0] w;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  result;
  logic              ovf;
  logic              busy;

  modport master (
    output start, in_valid, x, w, out_ready,
    input  in_ready, out_valid, result, ovf, busy
  );

  modport slave (
    input  start, in_valid, x, w, out_ready,
    output in_ready, out_valid, result, ovf, busy
  );
endinterface

// File: rtl/sm_mac_accumulator.sv
// -----------------------------------------------------------------------------
// sm_mac_accumulator
// Sign-magnitude multiply-accumulate engine computing one dot product of
// N_TERMS operand pairs per start. Two pipeline stages: stage 1 registers the
// product (sign = XOR of operand signs, magnitude = |x|*|w|); stage 2 folds a
// valid product into the sign-magnitude accumulator with saturation.
//
// Parameters
//   DATA_W  : operand width, sign-magnitude (DATA_W-1 magnitude bits)
//   ACC_W   : result width, sign-magnitude; needs ACC_W-1 >= 2*(DATA_W-1)
//   N_TERMS : operand pairs per dot product (>= 1)
//
// Ports
//   clk  : single clock, all state on the rising edge
//   rst  : asynchronous, active-high reset
//   bus  : sm_mac_if.slave (start, x/w beat handshake, result handshake,
//          ovf, busy)
//
// Configuration macro
//   SM_MAC_RELU_EN : when defined, a negative final sum is presented as 0 on
//                    result while in DONE. The accumulator itself and ovf are
//                    identical in both builds.
// -----------------------------------------------------------------------------
module sm_mac_accumulator #(
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 24,
  parameter int N_TERMS = 64
) (
  input  logic     clk,
  input  logic     rst,
  sm_mac_if.slave  bus
);

  localparam int MAG_W     = DATA_W - 1;          // operand magnitude bits
  localparam int PROD_W    = 2 * MAG_W;           // product magnitude bits
  localparam int ACC_MAG_W = ACC_W - 1;           // accumulator magnitude bits
  localparam int CNT_W     = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

  // Parameter legality is checked at elaboration time.
  if (ACC_MAG_W < PROD_W) begin : g_bad_acc_w
    $error("sm_mac_accumulator: ACC_W-1 must be >= 2*(DATA_W-1)");
  end
  if (N_TERMS < 1) begin : g_bad_n_terms
    $error("sm_mac_accumulator: N_TERMS must be >= 1");
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;

  logic w_start;   // start honoured this cycle
  logic w_accept;  // x/w beat accepted this cycle
  logic w_last;    // the accepted beat is the N_TERMS-th one

  assign w_start  = (r_state == S_IDLE) && bus.start;
  assign w_accept = (r_state == S_ACCUM) && bus.in_valid;
  assign w_last   = (r_cnt == LAST_CNT);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of its neighbours; blocking here would create ordering
  // races between always_ff blocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every output of this always_comb gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.start)                w_next_state = S_ACCUM;
      S_ACCUM: if (w_accept && w_last)       w_next_state = S_DRAIN;
      // One cycle lets the final product move from stage 1 into the sum.
      S_DRAIN:                               w_next_state = S_DONE;
      S_DONE:  if (bus.out_ready)            w_next_state = S_IDLE;
      default:                               w_next_state = S_IDLE;
    endcase
  end

  // Beat counter: counts accepted beats of the current dot product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_start) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: product register
  // ---------------------------------------------------------------------------
  logic [PROD_W-1:0] w_prod_mag;
  logic              w_prod_sign;

  assign w_prod_mag  = PROD_W'(bus.x[MAG_W-1:0]) * PROD_W'(bus.w[MAG_W-1:0]);
  // A zero product is always positive so it can never flip the sum negative.
  assign w_prod_sign = (bus.x[DATA_W-1] ^ bus.w[DATA_W-1]) && (w_prod_mag != '0);

  logic              r_p_vld;
  logic              r_p_sign;
  logic [PROD_W-1:0] r_p_mag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p_vld  <= 1'b0;
      r_p_sign <= 1'b0;
      r_p_mag  <= '0;
    end else if (w_start) begin
      r_p_vld  <= 1'b0;
    end else begin
      r_p_vld <= w_accept;
      if (w_accept) begin
        r_p_sign <= w_prod_sign;
        r_p_mag  <= w_prod_mag;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: sign-magnitude accumulate with saturation
  // ---------------------------------------------------------------------------
  logic                 r_acc_sign;
  logic [ACC_MAG_W-1:0] r_acc_mag;
  logic                 r_ovf;

  logic [ACC_MAG_W-1:0] w_p_ext;
  logic [ACC_MAG_W:0]   w_sum;      // one carry bit above the magnitude
  logic                 w_add_sign;
  logic [ACC_MAG_W-1:0] w_add_mag;
  logic                 w_add_ovf;

  assign w_p_ext = ACC_MAG_W'(r_p_mag);
  assign w_sum   = {1'b0, r_acc_mag} + {1'b0, w_p_ext};

  always_comb begin
    w_add_sign = r_acc_sign;
    w_add_mag  = r_acc_mag;
    w_add_ovf  = 1'b0;
    if (r_acc_sign == r_p_sign) begin
      // Same signs: magnitudes add; a carry out means the sum cannot be
      // represented, so clamp to full scale and keep the sign.
      if (w_sum[ACC_MAG_W]) begin
        w_add_mag = '1;
        w_add_ovf = 1'b1;
      end else begin
        w_add_mag = w_sum[ACC_MAG_W-1:0];
      end
    end else if (r_acc_mag >= w_p_ext) begin
      // Differing signs: the larger magnitude wins and lends its sign.
      w_add_mag  = r_acc_mag - w_p_ext;
      w_add_sign = r_acc_sign;
    end else begin
      w_add_mag  = w_p_ext - r_acc_mag;
      w_add_sign = r_p_sign;
    end
    // Canonical zero: never report -0.
    if (w_add_mag == '0) begin
      w_add_sign = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc_sign <= 1'b0;
      r_acc_mag  <= '0;
      r_ovf      <= 1'b0;
    end else if (w_start) begin
      r_acc_sign <= 1'b0;
      r_acc_mag  <= '0;
      r_ovf      <= 1'b0;
    end else if (r_p_vld) begin
      r_acc_sign <= w_add_sign;
      r_acc_mag  <= w_add_mag;
      if (w_add_ovf) begin
        r_ovf <= 1'b1;  // sticky until the next start
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.in_ready  = (r_state == S_ACCUM);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.ovf       = r_ovf;

`ifdef SM_MAC_RELU_EN
  // Rectify only the presented value; the accumulator keeps the raw sum.
  assign bus.result = ((r_state == S_DONE) && r_acc_sign) ? '0
                                                          : {r_acc_sign, r_acc_mag};
`else
  assign bus.result = {r_acc_sign, r_acc_mag};
`endif

  // ---------------------------------------------------------------------------
  // Protocol properties
  // ---------------------------------------------------------------------------
  // A result held under backpressure must not move.
  a_done_stable: assert property (@(posedge clk) disable iff (rst)
    (r_state == S_DONE && !bus.out_ready) |=> ($stable(bus.result) && $stable(bus.ovf)));

  // Input and output handshakes are never open at the same time.
  a_exclusive_hs: assert property (@(posedge clk) disable iff (rst)
    !(bus.in_ready && bus.out_valid));

  // No product may still be in flight once the result is offered.
  a_no_late_product: assert property (@(posedge clk) disable iff (rst)
    (r_state == S_DONE) |-> !r_p_vld);

endmodule

// File: tb/tb_sm_mac_accumulator.sv
module tb_sm_mac_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Two DUTs share one stimulus stream: a 24-bit accumulator and a 16-bit one
  // that saturates much sooner.
  sm_mac_if #(.DATA_W(8), .ACC_W(24)) if_a ();
  sm_mac_if #(.DATA_W(8), .ACC_W(16)) if_s ();

  assign if_s.start     = if_a.start;
  assign if_s.in_valid  = if_a.in_valid;
  assign if_s.x         = if_a.x;
  assign if_s.w         = if_a.w;
  assign if_s.out_ready = if_a.out_ready;

  sm_mac_accumulator #(.DATA_W(8), .ACC_W(24), .N_TERMS(4)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a)
  );

  sm_mac_accumulator #(.DATA_W(8), .ACC_W(16), .N_TERMS(4)) u_dut_s (
    .clk (clk),
    .rst (rst),
    .bus (if_s)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  bx [4];
  logic [7:0]  bw [4];
  logic [23:0] exp_a;
  logic [15:0] exp_s;
  bit          exp_ovf_a;
  bit          exp_ovf_s;

  // Reference: plain signed integer running sum, clamped to +/-(2^(acc_w-1)-1)
  // after every term, then encoded as sign-magnitude.
  function automatic logic [31:0] model_sm(input int acc_w, output bit ovf_o);
    longint s;
    longint mx;
    longint p;
    logic [7:0] xv;
    logic [7:0] wv;
    s     = 0;
    mx    = (longint'(1) << (acc_w - 1)) - 1;
    ovf_o = 1'b0;
    for (int k = 0; k < 4; k++) begin
      xv = bx[k];
      wv = bw[k];
      p  = longint'(xv[6:0]) * longint'(wv[6:0]);
      if (xv[7] ^ wv[7]) p = -p;
      s = s + p;
      if (s > mx)  begin s = mx;  ovf_o = 1'b1; end
      if (s < -mx) begin s = -mx; ovf_o = 1'b1; end
    end
`ifdef SM_MAC_RELU_EN
    if (s < 0) s = 0;
`endif
    if (s < 0) return (32'd1 << (acc_w - 1)) | 32'(-s);
    return 32'(s);
  endfunction

  task automatic compute_expected();
    logic [31:0] t;
    t     = model_sm(24, exp_ovf_a);
    exp_a = t[23:0];
    t     = model_sm(16, exp_ovf_s);
    exp_s = t[15:0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete dot product on the beats in bx/bw. gap_pct: chance of an
  // idle cycle before each beat; hold: cycles of out_ready low in DONE;
  // poke_start: pulse start while the result is held.
  task automatic run_dot(input string name, input int gap_pct, input int hold,
                         input bit poke_start);
    int guard;
    compute_expected();
    if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      guard = 0;
      while (gap_pct > 0 && $urandom_range(99) < gap_pct && guard < 6) begin
        if_a.in_valid = 1'b0;
        if_a.x        = 8'($urandom);
        if_a.w        = 8'($urandom);
        tick();
        guard++;
      end
      if_a.in_valid = 1'b1;
      if_a.x        = bx[k];
      if_a.w        = bw[k];
      n_checks++;
      if (if_a.in_ready !== 1'b1) begin
        n_errors++;
        $display("FAIL %s in_ready beat %0d: got %b want 1", name, k, if_a.in_ready);
      end
      tick();
    end
    if_a.in_valid = 1'b0;
    // Between the last beat edge and the next edge: not yet valid.
    n_checks++;
    if (if_a.out_valid !== 1'b0 || if_a.busy !== 1'b1) begin
      n_errors++;
      $display("FAIL %s early_valid: out_valid %b busy %b want 0 1", name, if_a.out_valid, if_a.busy);
    end
    tick();
    n_checks++;
    if (if_a.out_valid !== 1'b1 || if_s.out_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL %s out_valid_latency: got %b/%b want 1/1", name, if_a.out_valid, if_s.out_valid);
    end
    for (int h = 0; h <= hold; h++) begin
      n_checks++;
      if (if_a.result !== exp_a || if_a.ovf !== exp_ovf_a) begin
        n_errors++;
        $display("FAIL %s result24 cyc %0d: got %h ovf %b want %h ovf %b", name, h, if_a.result, if_a.ovf, exp_a, exp_ovf_a);
      end
      n_checks++;
      if (if_s.result !== exp_s || if_s.ovf !== exp_ovf_s) begin
        n_errors++;
        $display("FAIL %s result16 cyc %0d: got %h ovf %b want %h ovf %b", name, h, if_s.result, if_s.ovf, exp_s, exp_ovf_s);
      end
      n_checks++;
      if (if_a.out_valid !== 1'b1 || if_a.in_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL %s done_hold cyc %0d: out_valid %b in_ready %b want 1 0", name, h, if_a.out_valid, if_a.in_ready);
      end
      if (h == hold) begin
        if_a.start     = 1'b0;
        if_a.out_ready = 1'b1;
      end else begin
        if_a.start     = poke_start;
        if_a.out_ready = 1'b0;
      end
      tick();
    end
    if_a.out_ready = 1'b0;
    n_checks++;
    if (if_a.out_valid !== 1'b0 || if_a.busy !== 1'b0 || if_a.in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL %s after_handshake: out_valid %b busy %b in_ready %b want 0 0 0", name, if_a.out_valid, if_a.busy, if_a.in_ready);
    end
  endtask

  task automatic check_all_zero(input string name);
    n_checks++;
    if (if_a.result !== 24'h0 || if_a.ovf !== 1'b0 || if_a.out_valid !== 1'b0 ||
        if_a.in_ready !== 1'b0 || if_a.busy !== 1'b0 || if_s.result !== 16'h0 || if_s.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL %s outputs: result %h ovf %b out_valid %b in_ready %b busy %b want all 0",
               name, if_a.result, if_a.ovf, if_a.out_valid, if_a.in_ready, if_a.busy);
    end
  endtask

  task automatic set_beats(input logic [31:0] xs, input logic [31:0] ws);
    for (int k = 0; k < 4; k++) begin
      bx[k] = xs[8*(3-k) +: 8];
      bw[k] = ws[8*(3-k) +: 8];
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    check_all_zero("post_reset_idle");
  endtask

  task automatic test_basic();
    set_beats(32'h03030303, 32'h05050505);
    run_dot("basic", 0, 0, 1'b0);
    n_checks++;
    if (exp_a !== 24'h00003C) begin
      n_errors++;
      $display("FAIL basic_const: model %h want 00003c", exp_a);
    end
  endtask

  task automatic test_mixed_signs();
    set_beats(32'h0382_0103, 32'h0504_8A01);
    run_dot("mixed", 0, 0, 1'b0);
    n_checks++;
    if (if_a.result !== 24'h000000) begin
      n_errors++;
      $display("FAIL mixed_zero: got %h want 000000", if_a.result);
    end
  endtask

  task automatic test_back_to_back();
    set_beats(32'h8507_7F11, 32'h0A83_0222);
    run_dot("backpressure", 50, 5, 1'b1);
    set_beats(32'h0102_0304, 32'h8182_8384);
    run_dot("back_to_back", 30, 0, 1'b0);
  endtask

  task automatic test_saturation();
    set_beats(32'h7F7F7F7F, 32'h7F7F7F7F);
    run_dot("saturation", 0, 2, 1'b0);
    n_checks++;
    if (exp_s !== 16'h7FFF || exp_ovf_s !== 1'b1 || exp_a !== 24'h00FC04 || exp_ovf_a !== 1'b0) begin
      n_errors++;
      $display("FAIL saturation_const: model %h/%b %h/%b want 7fff/1 00fc04/0", exp_s, exp_ovf_s, exp_a, exp_ovf_a);
    end
  endtask

  task automatic test_reset_mid_run();
    set_beats(32'h7F7F7F7F, 32'hFFFFFFFF);
    if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if_a.in_valid = 1'b1;
      if_a.x        = bx[k];
      if_a.w        = bw[k];
      tick();
    end
    #2;
    rst = 1'b1;  // asserted between edges: must act without a clock
    #1;
    check_all_zero("reset_mid_async");
    if_a.in_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check_all_zero("reset_mid_idle");
    set_beats(32'h03030303, 32'h05050505);
    run_dot("reset_rerun", 0, 0, 1'b0);
    n_checks++;
    if (if_a.result !== 24'h00003C) begin
      n_errors++;
      $display("FAIL reset_rerun_const: got %h want 00003c", if_a.result);
    end
  endtask

  task automatic test_relu();
    logic [23:0] want;
`ifdef SM_MAC_RELU_EN
    want = 24'h000000;
`else
    want = 24'h80000C;
`endif
    set_beats(32'h8300_0180, 32'h0405_0085);
    compute_expected();
    n_checks++;
    if (exp_a !== want) begin
      n_errors++;
      $display("FAIL relu_model: model %h want %h", exp_a, want);
    end
    run_dot("relu", 0, 1, 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 4; k++) begin
        bx[k] = 8'($urandom);
        bw[k] = 8'($urandom);
        if (r[0]) begin
          bx[k][6:5] = 2'b11;  // large magnitudes to provoke 16-bit saturation
          bw[k][6:5] = 2'b11;
        end
      end
      run_dot($sformatf("random%0d", r), 40, int'($urandom_range(3)), r[1]);
    end
  endtask

  initial begin
    if_a.start     = 1'b0;
    if_a.in_valid  = 1'b0;
    if_a.x         = '0;
    if_a.w         = '0;
    if_a.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_mixed_signs();
    test_back_to_back();
    test_saturation();
    test_reset_mid_run();
    test_relu();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
